// File: rtl/regfile_pkg.sv
// Shared defaults and state type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Zero-fill sequencer: walks every entry once after reset or clr, then reports ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  output logic                     fill_we,
  output logic [$clog2(NREG)-1:0]  fill_addr
);

  localparam int unsigned AW = $clog2(NREG);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clr restarts the walk from entry 0; the last entry's edge hands over to READY
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = RF_CLEAR;
      ptr_d   = '0;
    end else if (state_q == RF_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(NREG - 1)) state_d = RF_READY;
    end
  end

  assign ready     = (state_q == RF_READY);
  assign fill_we   = (state_q == RF_CLEAR);
  assign fill_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, write-through reads and self-clearing storage.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [NRD*$clog2(NREG)-1:0]     raddr,
  input  logic [NRD-1:0]                  ren,
  output logic [NRD*XLEN-1:0]             rdata,
  input  logic [NWR*$clog2(NREG)-1:0]     waddr,
  input  logic [NWR*XLEN-1:0]             wdata,
  input  logic [NWR-1:0]                  wen,
  output logic                            ready
);

  localparam int unsigned AW = $clog2(NREG);

  logic              fill_we;
  logic [AW-1:0]     fill_addr;
  logic              user_we;
  logic [XLEN-1:0]   mem_q [NREG];
  logic [XLEN-1:0]   rd_val [NRD];
  logic [NRD*XLEN-1:0] rdata_q, rdata_d;

  regfile_clear_fsm #(
    .NREG (NREG)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .ready     (ready),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  assign user_we = ready && !clr;

  // Later ports overwrite earlier ones within the same edge, so the highest port wins
  always_ff @(posedge clk) begin
    if (fill_we && !clr) begin
      mem_q[fill_addr] <= '0;
    end else if (user_we) begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && (waddr[p*AW +: AW] != '0)) begin
          mem_q[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read value with bypass of the winning same-cycle write; x0 never bypasses
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_val[r] = mem_q[raddr[r*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && (waddr[p*AW +: AW] == raddr[r*AW +: AW])) begin
          rd_val[r] = wdata[p*XLEN +: XLEN];
        end
      end
      if (raddr[r*AW +: AW] == '0) rd_val[r] = '0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (!user_we) begin
      rdata_d = '0;
    end else begin
      for (int r = 0; r < NRD; r++) begin
        if (ren[r]) rdata_d[r*XLEN +: XLEN] = rd_val[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: array-level reference model, queued expectations, negedge monitor.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct {
    int          kind;   // 0: rdata port, 1: ready
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              clr;
  logic [1:0]        ren;
  logic [1:0]        wen;
  logic [AW-1:0]     ra [2];
  logic [AW-1:0]     wa [2];
  logic [XLEN-1:0]   wd [2];
  logic [2*AW-1:0]   raddr;
  logic [2*AW-1:0]   waddr;
  logic [2*XLEN-1:0] wdata;
  logic [2*XLEN-1:0] rdata;
  logic              ready;

  assign raddr = {ra[1], ra[0]};
  assign waddr = {wa[1], wa[0]};
  assign wdata = {wd[1], wd[0]};

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (2),
    .NWR  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .raddr (raddr),
    .ren   (ren),
    .rdata (rdata),
    .waddr (waddr),
    .wdata (wdata),
    .wen   (wen),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];

  logic [31:0] m_mem [NREG];
  logic [31:0] m_rd  [2];
  int          fill_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Array-level model: after a clear the whole array is zero and needs NREG edges to come back
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    fill_left = NREG;
  endtask

  task automatic model_edge();
    logic [31:0] nxt [NREG];
    exp_t e;
    if (clr) begin
      model_reset();
    end else if (fill_left > 0) begin
      fill_left--;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      nxt = m_mem;
      for (int p = 0; p < 2; p++)
        if (wen[p] && wa[p] != 0) nxt[wa[p]] = wd[p];
      for (int r = 0; r < 2; r++)
        if (ren[r]) m_rd[r] = nxt[ra[r]];
      m_mem = nxt;
    end
    for (int r = 0; r < 2; r++) begin
      e.kind = 0; e.port = r; e.exp = m_rd[r];
      sb.push_back(e);
    end
    e.kind = 1; e.port = 0; e.exp = (fill_left == 0) ? 32'd1 : 32'd0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 0) check($sformatf("rdata[%0d]", e.port), rdata[e.port*XLEN +: XLEN], e.exp);
      else             check("ready", {31'd0, ready}, e.exp);
    end
  end

  task automatic idle();
    clr = 1'b0; ren = '0; wen = '0;
    ra[0] = '0; ra[1] = '0; wa[0] = '0; wa[1] = '0;
    wd[0] = '0; wd[1] = '0;
  endtask

  task automatic rand_inputs(input int addr_max, input bit allow_clr);
    clr = allow_clr ? ($urandom_range(0, 59) == 0) : 1'b0;
    ren = 2'($urandom_range(0, 3));
    wen = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      ra[i] = AW'($urandom_range(0, addr_max));
      wa[i] = AW'($urandom_range(0, addr_max));
      wd[i] = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Random traffic while clearing exercises the ignore-in-CLEAR behaviour
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      rand_inputs(31, 1'b0);
      tick();
      n++;
    end
    idle();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst rdata[0] immediate", rdata[31:0], 32'd0);
    check("rst rdata[1] immediate", rdata[63:32], 32'd0);
    check("rst ready immediate", {31'd0, ready}, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset rdata", rdata[31:0] | rdata[63:32], 32'd0);
    rst = 1'b0;

    wait_ready(n);
    check("edges to ready after rst", 32'(n), 32'd32);

    // x5 reads zero after the fill
    ren = 2'b01; ra[0] = 5'd5;
    tick(); idle();

    wen = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    tick(); idle();
    ren = 2'b01; ra[0] = 5'd5;
    tick(); idle();

    // Same-address collision, then read on both ports
    wen = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h1111; wd[1] = 32'h2222;
    tick(); idle();
    ren = 2'b11; ra[0] = 5'd7; ra[1] = 5'd7;
    tick(); idle();

    // Write-through and x0
    wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'hA5A5; ren = 2'b10; ra[1] = 5'd3;
    tick(); idle();
    wen = 2'b10; wa[1] = 5'd0; wd[1] = 32'hFFFF; ren = 2'b01; ra[0] = 5'd0;
    tick(); idle();
    ren = 2'b11; ra[0] = 5'd0; ra[1] = 5'd3;
    tick(); idle();
    tick();

    // clr drops the concurrent write and restarts the fill
    wen = 2'b01; wa[0] = 5'd9; wd[0] = 32'h1234;
    tick(); idle();
    clr = 1'b1; wen = 2'b10; wa[1] = 5'd10; wd[1] = 32'h5678;
    tick(); idle();
    wait_ready(n);
    check("edges to ready after clr", 32'(n + 1), 32'd33);
    ren = 2'b11; ra[0] = 5'd9; ra[1] = 5'd10;
    tick(); idle();

    // Random traffic on a narrow address range to force collisions
    for (int i = 0; i < 400; i++) begin
      rand_inputs(7, 1'b1);
      tick();
    end
    idle();
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end

    // Reset while holding nonzero read data
    wen = 2'b01; wa[0] = 5'd12; wd[0] = 32'hCAFE0001;
    tick(); idle();
    ren = 2'b11; ra[0] = 5'd12; ra[1] = 5'd12;
    tick(); idle();
    do_reset();
    wait_ready(n);
    check("edges to ready after mid-op rst", 32'(n), 32'd32);

    // Reset ten edges into a clear sequence
    clr = 1'b1;
    tick(); idle();
    repeat (10) tick();
    do_reset();
    wait_ready(n);
    check("edges to ready after mid-clear rst", 32'(n), 32'd32);
    ren = 2'b11; ra[0] = 5'd12; ra[1] = 5'd5;
    tick(); idle();
    tick();

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
